// File: rtl/lx32_pkg.sv
// Shared types for the lx32 memory arbiter: FSM state, owner encoding and a
// helper that picks the response word returned to the requester.
package lx32_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } arb_state_e;

   typedef enum logic {
      INSTR = 1'b0,
      DATA  = 1'b1
   } arb_owner_e;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned XLEN   = 32;

   // Writes and timeouts return zero; only a completed read returns memory data.
   function automatic logic [XLEN-1:0] resp_data(input logic          ready,
                                                  input logic          we,
                                                  input logic [XLEN-1:0] rdata);
      return (ready && !we) ? rdata : '0;
   endfunction

endpackage

// File: rtl/arb_timeout_counter.sv
// Busy-cycle watchdog for lx32_mem_arbiter; compiled only when
// LX32_ARB_TIMEOUT_EN is defined.
`ifdef LX32_ARB_TIMEOUT_EN
module arb_timeout_counter #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic busy,
   input  logic m_ready,
   output logic expired
);

   localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CW-1:0] cnt;

   // Fires during the TIMEOUT_CYCLES-th consecutive busy cycle without m_ready.
   assign expired = busy && ((32'(cnt) + 32'd1) >= TIMEOUT_CYCLES);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (!busy || m_ready) begin
         cnt <= '0;
      end else if (!expired) begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule
`endif

// File: rtl/lx32_mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter onto one single-port memory.
// Optional watchdog enabled by defining LX32_ARB_TIMEOUT_EN.
module lx32_mem_arbiter
   import lx32_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        m_req,
   output logic        m_we,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic        m_ready,
   input  logic [31:0] m_rdata,
   output logic        err_timeout
);

   arb_state_e state;
   arb_owner_e last_owner;
   logic       idle;
   logic       grant_i;
   logic       grant_d;
   logic       expired;
   logic       finish;

   assign idle = (state == IDLE);

   // On contention the requester that did not own the last grant wins.
   assign grant_i = idle && if_req && (!d_req || (last_owner == DATA));
   assign grant_d = idle && d_req && !grant_i;
   assign if_gnt  = grant_i;
   assign d_gnt   = grant_d;

   assign finish = !idle && (m_ready || expired);

`ifdef LX32_ARB_TIMEOUT_EN
   arb_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .busy   (!idle),
      .m_ready(m_ready),
      .expired(expired)
   );

   // A same-cycle m_ready wins over the watchdog and leaves the flag alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_timeout <= 1'b0;
      end else if (!idle && expired && !m_ready) begin
         err_timeout <= 1'b1;
      end
   end
`else
   assign expired     = 1'b0;
   assign err_timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_owner <= DATA;
         m_req      <= 1'b0;
         m_we       <= 1'b0;
         m_addr     <= '0;
         m_wdata    <= '0;
         if_rvalid  <= 1'b0;
         if_rdata   <= '0;
         d_rvalid   <= 1'b0;
         d_rdata    <= '0;
      end else begin
         if_rvalid <= 1'b0;
         d_rvalid  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (grant_i) begin
                  state      <= BUSY_I;
                  last_owner <= INSTR;
                  m_req      <= 1'b1;
                  m_we       <= 1'b0;
                  m_addr     <= if_addr;
                  m_wdata    <= '0;
               end else if (grant_d) begin
                  state      <= BUSY_D;
                  last_owner <= DATA;
                  m_req      <= 1'b1;
                  m_we       <= d_we;
                  m_addr     <= d_addr;
                  m_wdata    <= d_wdata;
               end
            end
            BUSY_I, BUSY_D: begin
               if (finish) begin
                  state <= IDLE;
                  m_req <= 1'b0;
                  m_we  <= 1'b0;
                  if (state == BUSY_I) begin
                     if_rvalid <= 1'b1;
                     if_rdata  <= resp_data(m_ready, m_we, m_rdata);
                  end else begin
                     d_rvalid <= 1'b1;
                     d_rdata  <= resp_data(m_ready, m_we, m_rdata);
                  end
               end
            end
            default: begin
               state <= IDLE;
               m_req <= 1'b0;
               m_we  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lx32_mem_arbiter.sv
// Scoreboard bench for lx32_mem_arbiter: directed transactions push expected
// responses, a negedge monitor pops them on every rvalid.
module tb_lx32_mem_arbiter;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        m_req;
   logic        m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic        m_ready = 1'b0;
   logic [31:0] m_rdata = '0;
   logic        err_timeout;

   typedef struct packed {
      logic        is_d;
      logic [31:0] data;
   } resp_t;

   resp_t exp_q[$];
   int    n_checks = 0;
   int    n_fail = 0;

   lx32_mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_ready(m_ready), .m_rdata(m_rdata),
      .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: every rvalid must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst) begin
         if (if_rvalid && d_rvalid) check("both_rvalid", 32'd1, 32'd0);
         if (if_rvalid || d_rvalid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_rvalid", {31'd0, d_rvalid}, 32'hFFFF_FFFF);
            end else begin
               resp_t e;
               e = exp_q.pop_front();
               check("rvalid_port", {31'd0, d_rvalid}, {31'd0, e.is_d});
               check("rdata", d_rvalid ? d_rdata : if_rdata, e.data);
            end
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; m_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic expect_drained();
      @(negedge clk);
      #1 check("queue_drained", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   // Entered and left at posedge+1; leaves in the cycle after the response edge.
   task automatic run_txn(input bit is_d, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int k, input bit hold);
      resp_t e;
      if (is_d) begin
         d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
      end else begin
         if_req = 1'b1; if_addr = addr;
      end
      @(negedge clk);
      check("gnt_own", {31'd0, is_d ? d_gnt : if_gnt}, 32'd1);
      check("gnt_other", {31'd0, is_d ? if_gnt : d_gnt}, 32'd0);
      e.is_d = is_d;
      e.data = we ? 32'h0 : rdata;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (!hold) begin
         if_req = 1'b0; d_req = 1'b0;
      end
      for (int i = 1; i <= k; i++) begin
         m_ready = (i == k);
         m_rdata = (i == k) ? rdata : 32'hBAD0_BAD0;
         @(negedge clk);
         check("m_req_busy", {31'd0, m_req}, 32'd1);
         check("m_addr", m_addr, addr);
         check("m_we", {31'd0, m_we}, {31'd0, is_d & we});
         if (we) check("m_wdata", m_wdata, wdata);
         check("gnt_busy", {30'd0, if_gnt, d_gnt}, 32'd0);
         @(posedge clk);
         #1;
      end
      m_ready = 1'b0;
      m_rdata = 32'h0;
   endtask

   initial begin
      #2;
      @(negedge clk);
      check("rst_m_req", {31'd0, m_req}, 32'd0);
      check("rst_m_addr", m_addr, 32'h0);
      check("rst_rdata", if_rdata | d_rdata, 32'h0);
      check("rst_err", {31'd0, err_timeout}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Single fetch, memory answers on the second busy cycle.
      run_txn(1'b0, 1'b0, 32'h100, 32'h0, 32'h0050_0093, 2, 1'b0);
      @(negedge clk);
      check("fetch_m_req_done", {31'd0, m_req}, 32'd0);
      @(posedge clk);
      #1;
      expect_drained();

      // Contention after reset alternates I, D, I, D.
      do_reset();
      d_req = 1'b1; d_addr = 32'h3000; d_we = 1'b0;
      run_txn(1'b0, 1'b0, 32'h200, 32'h0, 32'h1111_0001, 1, 1'b1);
      run_txn(1'b1, 1'b0, 32'h3000, 32'h0, 32'h2222_0002, 2, 1'b1);
      run_txn(1'b0, 1'b0, 32'h200, 32'h0, 32'h3333_0003, 1, 1'b1);
      run_txn(1'b1, 1'b0, 32'h3000, 32'h0, 32'h4444_0004, 3, 1'b0);
      expect_drained();

      // Store: zero response, fetch data left untouched.
      run_txn(1'b1, 1'b1, 32'h2000, 32'hCAFE_BABE, 32'h5555_5555, 1, 1'b0);
      expect_drained();
      check("if_rdata_held", if_rdata, 32'h3333_0003);

      // m_ready on an idle bus must not produce a response.
      m_ready = 1'b1; m_rdata = 32'hDEAD_BEEF;
      repeat (2) @(posedge clk);
      #1 m_ready = 1'b0;
      expect_drained();

      // Ready arriving exactly on the watchdog cycle completes normally.
      run_txn(1'b1, 1'b0, 32'h4400, 32'h0, 32'h6666_0006, TO, 1'b0);
      expect_drained();
      check("err_simul", {31'd0, err_timeout}, 32'd0);

      // Reset in the middle of a data transaction abandons it.
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4000;
      @(negedge clk);
      check("mid_gnt", {31'd0, d_gnt}, 32'd1);
      @(posedge clk);
      #1 d_req = 1'b0;
      @(negedge clk);
      check("mid_m_req", {31'd0, m_req}, 32'd1);
      #2 rst = 1'b1;
      #1 check("mid_m_req_rst", {31'd0, m_req}, 32'd0);
      m_ready = 1'b1; m_rdata = 32'h7777_7777;
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 m_ready = 1'b0;
      expect_drained();
      d_req = 1'b1; d_addr = 32'h3000; d_we = 1'b0;
      run_txn(1'b0, 1'b0, 32'h300, 32'h0, 32'h8888_0008, 1, 1'b0);
      expect_drained();

`ifdef LX32_ARB_TIMEOUT_EN
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h5000;
      @(negedge clk);
      check("tmo_gnt", {31'd0, d_gnt}, 32'd1);
      begin
         resp_t e;
         e.is_d = 1'b1;
         e.data = 32'h0;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1 d_req = 1'b0;
      for (int i = 0; i < TO; i++) begin
         @(negedge clk);
         check("tmo_m_req_busy", {31'd0, m_req}, 32'd1);
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      check("tmo_m_req_drop", {31'd0, m_req}, 32'd0);
      check("tmo_err_set", {31'd0, err_timeout}, 32'd1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("tmo_err_sticky", {31'd0, err_timeout}, 32'd1);
      @(posedge clk);
      #1;
      expect_drained();
`else
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h5000;
      @(negedge clk);
      check("wait_gnt", {31'd0, d_gnt}, 32'd1);
      @(posedge clk);
      #1 d_req = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         check("wait_m_req", {31'd0, m_req}, 32'd1);
         check("wait_err", {31'd0, err_timeout}, 32'd0);
         @(posedge clk);
         #1;
      end
      do_reset();
      expect_drained();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "simulation time limit exceeded");
   end

endmodule
